// File: rtl/clk_div_multi.sv
// Multi-channel clock divider and tick generator.
// Each channel produces a 50% duty divided clock with a half-period of
// div_act cycles, plus a one-cycle tick in every cycle its clock rises.
// Divisors are written through a shadow register and applied at the next
// half-period boundary, so a running channel never produces a short pulse.
module clk_div_multi #(
    parameter int          NCH      = 3,
    parameter int          CW       = 32,
    parameter int          CHW      = 2,
    parameter int unsigned DIV_INIT = 50000000
) (
    input  logic            CLK,
    input  logic            rst,
    input  logic            en,
    input  logic            wr_en,
    input  logic [CHW-1:0]  wr_ch,
    input  logic [CW-1:0]   wr_div,
    output logic            wr_err,
    output logic [NCH-1:0]  pending,
    output logic [NCH-1:0]  clk_out,
    output logic [NCH-1:0]  tick
);

    logic [NCH-1:0][CW-1:0] cnt_q,     cnt_d;
    logic [NCH-1:0][CW-1:0] div_act_q, div_act_d;
    logic [NCH-1:0][CW-1:0] div_shd_q, div_shd_d;
    logic [NCH-1:0]         pending_q, pending_d;
    logic [NCH-1:0]         clk_q,     clk_d;
    logic [NCH-1:0]         tick_q,    tick_d;
    logic                   wr_err_q,  wr_err_d;
    logic                   wrValid;

    // A write is only honoured when it addresses an existing channel.
    always_comb begin
        wrValid  = wr_en && (int'(wr_ch) < NCH);
        wr_err_d = wr_en && !wrValid;
    end

    // Per-channel next state: counting, boundary handling, divisor updates.
    always_comb begin
        cnt_d     = cnt_q;
        div_act_d = div_act_q;
        div_shd_d = div_shd_q;
        pending_d = pending_q;
        clk_d     = clk_q;
        tick_d    = '0;
        for (int i = 0; i < NCH; i++) begin
            if (div_act_q[i] == '0) begin
                // A stopped channel sits low and loads a new divisor directly.
                cnt_d[i] = '0;
                clk_d[i] = 1'b0;
                if (wrValid && (wr_ch == CHW'(i))) begin
                    div_act_d[i] = wr_div;
                end
            end else begin
                if (en) begin
                    if (cnt_q[i] >= div_act_q[i] - CW'(1)) begin
                        cnt_d[i] = '0;
                        if (pending_q[i]) begin
                            div_act_d[i] = div_shd_q[i];
                            pending_d[i] = 1'b0;
                            if (div_shd_q[i] != '0) begin
                                clk_d[i]  = ~clk_q[i];
                                tick_d[i] = ~clk_q[i];
                            end else begin
                                clk_d[i] = 1'b0;
                            end
                        end else begin
                            clk_d[i]  = ~clk_q[i];
                            tick_d[i] = ~clk_q[i];
                        end
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
                // The shadow write comes after the boundary so a coinciding
                // boundary still uses the previous shadow value.
                if (wrValid && (wr_ch == CHW'(i))) begin
                    div_shd_d[i] = wr_div;
                    pending_d[i] = 1'b1;
                end
            end
        end
    end

    // State registers with synchronous active-low reset to the initial divisor.
    always_ff @(posedge CLK) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]     <= '0;
                div_act_q[i] <= CW'(DIV_INIT);
                div_shd_q[i] <= CW'(DIV_INIT);
            end
            pending_q <= '0;
            clk_q     <= '0;
            tick_q    <= '0;
            wr_err_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_act_q <= div_act_d;
            div_shd_q <= div_shd_d;
            pending_q <= pending_d;
            clk_q     <= clk_d;
            tick_q    <= tick_d;
            wr_err_q  <= wr_err_d;
        end
    end

    assign wr_err  = wr_err_q;
    assign pending = pending_q;
    assign clk_out = clk_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi with small divisors (DIV_INIT=4, NCH=3, CW=8).
// A cycle model tracks, per channel, the cycles left until the next edge,
// the output level and the shadow divisor; a compare process checks the
// DUT against it every cycle, and directed steps pin known values.
module tb_clk_div_multi;

    logic       CLK;
    logic       rst;
    logic       en;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wr_div;
    logic       wr_err;
    logic [2:0] pending;
    logic [2:0] clk_out;
    logic [2:0] tick;

    int vectorCount = 0;
    int missCount   = 0;
    bit checkEn     = 0;

    int mDiv[3];
    int mShd[3];
    int mLeft[3];
    bit mPend[3];
    bit mLevel[3];
    bit mTick[3];
    bit mErr;

    clk_div_multi #(.NCH(3), .CW(8), .CHW(2), .DIV_INIT(4)) dut (
        .CLK     (CLK),
        .rst     (rst),
        .en      (en),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_div  (wr_div),
        .wr_err  (wr_err),
        .pending (pending),
        .clk_out (clk_out),
        .tick    (tick)
    );

    // Free-running 100 MHz clock.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Model: each channel counts down the cycles remaining in its half-period.
    always @(posedge CLK) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                mDiv[i] = 4; mShd[i] = 4; mLeft[i] = 4;
                mPend[i] = 0; mLevel[i] = 0; mTick[i] = 0;
            end
            mErr = 0;
        end else begin
            mErr = wr_en && (int'(wr_ch) >= 3);
            for (int i = 0; i < 3; i++) begin
                bit wr;
                wr = wr_en && (int'(wr_ch) == i);
                mTick[i] = 0;
                if (mDiv[i] == 0) begin
                    mLevel[i] = 0;
                    mLeft[i]  = 0;
                    if (wr) begin
                        mDiv[i]  = int'(wr_div);
                        mLeft[i] = int'(wr_div);
                    end
                end else begin
                    if (en) begin
                        if (mLeft[i] > 1) begin
                            mLeft[i]--;
                        end else begin
                            if (mPend[i]) begin
                                mDiv[i]  = mShd[i];
                                mPend[i] = 0;
                            end
                            mLeft[i] = mDiv[i];
                            if (mDiv[i] != 0) begin
                                mLevel[i] = !mLevel[i];
                                mTick[i]  = mLevel[i];
                            end else begin
                                mLevel[i] = 0;
                            end
                        end
                    end
                    if (wr) begin
                        mShd[i]  = int'(wr_div);
                        mPend[i] = 1;
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Compare process: DUT outputs against the model, away from the edge.
    always @(negedge CLK) begin
        if (checkEn) begin
            checkOutput("model_clk_out", 32'(clk_out), 32'({mLevel[2], mLevel[1], mLevel[0]}));
            checkOutput("model_tick",    32'(tick),    32'({mTick[2], mTick[1], mTick[0]}));
            checkOutput("model_pending", 32'(pending), 32'({mPend[2], mPend[1], mPend[0]}));
            checkOutput("model_wr_err",  32'(wr_err),  32'(mErr));
        end
    end

    task automatic applyStimulus(input logic enV, input logic wrEnV,
                                 input logic [1:0] chV, input logic [7:0] divV);
        en     = enV;
        wr_en  = wrEnV;
        wr_ch  = chV;
        wr_div = divV;
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        int guard;
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 2'd0, 8'd0);
        stepCycles(2);
        checkEn = 1;
        checkOutput("reset_clk_out", 32'(clk_out), 32'h0);
        checkOutput("reset_tick",    32'(tick),    32'h0);
        checkOutput("reset_pending", 32'(pending), 32'h0);
        checkOutput("reset_wr_err",  32'(wr_err),  32'h0);

        // Release reset: first rise four cycles later, period eight.
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 2'd0, 8'd0);
        stepCycles(3);
        checkOutput("pre_rise_clk", 32'(clk_out), 32'h0);
        stepCycles(1);
        checkOutput("rise_clk",  32'(clk_out), 32'h7);
        checkOutput("rise_tick", 32'(tick),    32'h7);
        stepCycles(1);
        checkOutput("post_rise_tick", 32'(tick),    32'h0);
        checkOutput("post_rise_clk",  32'(clk_out), 32'h7);
        stepCycles(3);
        checkOutput("fall_clk", 32'(clk_out), 32'h0);

        // Channel 1 divisor 2 written mid-period, applied at its boundary.
        stepCycles(2);
        applyStimulus(1'b1, 1'b1, 2'd1, 8'd2);
        stepCycles(1);
        applyStimulus(1'b1, 1'b0, 2'd0, 8'd0);
        checkOutput("ch1_pending", 32'(pending), 32'h2);
        stepCycles(1);
        checkOutput("ch1_applied_pending", 32'(pending), 32'h0);
        checkOutput("ch1_applied_clk",     32'(clk_out), 32'h7);
        stepCycles(2);
        checkOutput("ch1_fast_fall", 32'(clk_out), 32'h5);
        stepCycles(2);
        checkOutput("ch1_fast_rise_clk",  32'(clk_out), 32'h2);
        checkOutput("ch1_fast_rise_tick", 32'(tick),    32'h2);

        // Channel 2 stopped through the shadow, then restarted directly.
        applyStimulus(1'b1, 1'b1, 2'd2, 8'd0);
        stepCycles(1);
        applyStimulus(1'b1, 1'b0, 2'd0, 8'd0);
        checkOutput("ch2_stop_pending", 32'(pending[2]), 32'h1);
        stepCycles(3);
        checkOutput("ch2_stopped_pending", 32'(pending[2]), 32'h0);
        checkOutput("ch2_stopped_clk",     32'(clk_out[2]), 32'h0);
        stepCycles(1);
        applyStimulus(1'b1, 1'b1, 2'd2, 8'd3);
        stepCycles(1);
        applyStimulus(1'b1, 1'b0, 2'd0, 8'd0);
        checkOutput("ch2_restart_pending", 32'(pending[2]), 32'h0);
        stepCycles(2);
        checkOutput("ch2_restart_low", 32'(clk_out[2]), 32'h0);
        stepCycles(1);
        checkOutput("ch2_restart_rise", 32'(clk_out[2]), 32'h1);
        checkOutput("ch2_restart_tick", 32'(tick[2]),    32'h1);

        // Freeze all channels for five cycles mid-period, then resume.
        stepCycles(2);
        applyStimulus(1'b0, 1'b0, 2'd0, 8'd0);
        stepCycles(5);
        checkOutput("frozen_tick", 32'(tick), 32'h0);
        applyStimulus(1'b1, 1'b0, 2'd0, 8'd0);
        stepCycles(12);

        // Invalid channel write flags an error and changes nothing.
        applyStimulus(1'b1, 1'b1, 2'd3, 8'd7);
        stepCycles(1);
        applyStimulus(1'b1, 1'b0, 2'd0, 8'd0);
        checkOutput("bad_ch_err",     32'(wr_err),  32'h1);
        checkOutput("bad_ch_pending", 32'(pending), 32'h0);
        stepCycles(1);
        checkOutput("bad_ch_err_clear", 32'(wr_err), 32'h0);

        // Write landing exactly on a channel 0 boundary.
        guard = 0;
        while (!(mLeft[0] == 1 && mDiv[0] != 0) && guard < 40) begin
            stepCycles(1);
            guard++;
        end
        if (guard >= 40) begin
            vectorCount++; missCount++;
            $display("[TB] FAIL boundary_wait: got timeout expected ch0 boundary");
        end
        applyStimulus(1'b1, 1'b1, 2'd0, 8'd6);
        stepCycles(1);
        applyStimulus(1'b1, 1'b0, 2'd0, 8'd0);
        checkOutput("boundary_write_pending", 32'(pending[0]), 32'h1);
        stepCycles(14);

        // Back-to-back writes to channel 1: the last one wins.
        applyStimulus(1'b1, 1'b1, 2'd1, 8'd5);
        stepCycles(1);
        applyStimulus(1'b1, 1'b1, 2'd1, 8'd3);
        stepCycles(1);
        applyStimulus(1'b1, 1'b0, 2'd0, 8'd0);
        stepCycles(20);

        // Reset while channel 0 is high with a pending divisor.
        guard = 0;
        while (!(mLevel[0] && mLeft[0] > 2 && !mPend[0]) && guard < 40) begin
            stepCycles(1);
            guard++;
        end
        if (guard >= 40) begin
            vectorCount++; missCount++;
            $display("[TB] FAIL high_wait: got timeout expected ch0 high");
        end
        applyStimulus(1'b1, 1'b1, 2'd0, 8'd9);
        stepCycles(1);
        applyStimulus(1'b1, 1'b0, 2'd0, 8'd0);
        checkOutput("pre_reset_pending", 32'(pending[0]), 32'h1);
        checkOutput("pre_reset_clk",     32'(clk_out[0]), 32'h1);
        rst = 1'b0;
        stepCycles(1);
        checkOutput("mid_reset_clk",     32'(clk_out), 32'h0);
        checkOutput("mid_reset_tick",    32'(tick),    32'h0);
        checkOutput("mid_reset_pending", 32'(pending), 32'h0);
        rst = 1'b1;
        stepCycles(3);
        checkOutput("restart_low", 32'(clk_out), 32'h0);
        stepCycles(1);
        checkOutput("restart_rise", 32'(clk_out), 32'h7);
        stepCycles(4);
        checkOutput("restart_fall", 32'(clk_out), 32'h0);

        checkEn = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
